collision_probe: RTL

COLLISION_PROBE -- requirements
Module: collision_probe

---
 rtl/collision_probe_pkg.sv | 49 ++++
 rtl/collision_probe_if.sv | 12 +
 rtl/collision_probe_probe_point_gen.sv | 54 +++++
 rtl/collision_probe.sv | 96 +++++++++
 4 files changed

// File: rtl/collision_probe_pkg.sv
// Shared constants for the collision probe and tile map: tile geometry, FSM encoding, point indices.
// Point count is 4, or 8 when PROBE_MIDPOINT_EN is defined.
package collision_probe_pkg;

    localparam int TILE    = 32;
    localparam int LEFT    = 143;
    localparam int TOP     = 34;
    localparam int ROW_MAX = 15;
    localparam int COL_MAX = 19;

`ifdef PROBE_MIDPOINT_EN
    localparam int N_PTS = 8;
`else
    localparam int N_PTS = 4;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef logic [2:0] pt_idx_t;

    localparam pt_idx_t PT_TL   = 3'd0;
    localparam pt_idx_t PT_TR   = 3'd1;
    localparam pt_idx_t PT_BL   = 3'd2;
    localparam pt_idx_t PT_BR   = 3'd3;
    localparam pt_idx_t PT_TM   = 3'd4;
    localparam pt_idx_t PT_BM   = 3'd5;
    localparam pt_idx_t PT_LM   = 3'd6;
    localparam pt_idx_t PT_RM   = 3'd7;
    localparam pt_idx_t PT_LAST = pt_idx_t'(N_PTS - 1);

    function automatic int tile_col(input int x);
        return (x - LEFT) / TILE;
    endfunction

    function automatic int tile_row(input int y);
        return (y - TOP) / TILE;
    endfunction

    // Pixels left of/above the play field or beyond the last tile are off-map.
    function automatic logic in_map(input int x, input int y);
        return (x >= LEFT) && (y >= TOP) &&
               (tile_col(x) <= COL_MAX) && (tile_row(y) <= ROW_MAX);
    endfunction

endpackage

// File: rtl/collision_probe_if.sv
// Tile-map query bus: probe presents qx/qy with qvalid, map answers qdata in the same cycle.
interface collision_probe_if;

    logic [9:0] qx;
    logic [9:0] qy;
    logic       qvalid;
    logic       qdata;

    modport master (output qx, output qy, output qvalid, input qdata);
    modport slave  (input qx, input qy, input qvalid, output qdata);

endinterface

// File: rtl/collision_probe_probe_point_gen.sv
// Combinational hitbox point generator: index -> query coordinates plus 11-bit overflow flag.
// Midpoint indices 4..7 exist only when PROBE_MIDPOINT_EN is defined.
module probe_point_gen
    import collision_probe_pkg::*;
#(
    parameter int HIT_W = 31,
    parameter int HIT_H = 31
) (
    input  logic [9:0] base_x,
    input  logic [9:0] base_y,
    input  pt_idx_t    idx,
    output logic [9:0] qx,
    output logic [9:0] qy,
    output logic       ovf
);

    localparam logic [10:0] OFF_W = 11'(HIT_W);
    localparam logic [10:0] OFF_H = 11'(HIT_H);
`ifdef PROBE_MIDPOINT_EN
    localparam logic [10:0] MID_W = 11'(HIT_W / 2);
    localparam logic [10:0] MID_H = 11'(HIT_H / 2);
`endif

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] sum_x;
    logic [10:0] sum_y;

    always_comb begin
        dx = '0;
        dy = '0;
        case (idx)
            PT_TL: ;
            PT_TR: dx = OFF_W;
            PT_BL: dy = OFF_H;
            PT_BR: begin dx = OFF_W; dy = OFF_H; end
`ifdef PROBE_MIDPOINT_EN
            PT_TM: dx = MID_W;
            PT_BM: begin dx = MID_W; dy = OFF_H; end
            PT_LM: dy = MID_H;
            PT_RM: begin dx = OFF_W; dy = MID_H; end
`endif
            default: ;
        endcase
    end

    assign sum_x = {1'b0, base_x} + dx;
    assign sum_y = {1'b0, base_y} + dy;
    assign qx    = sum_x[9:0];
    assign qy    = sum_y[9:0];
    // Bit 10 set means the point lies past pixel 1023 and counts as solid.
    assign ovf   = sum_x[10] | sum_y[10];

endmodule

// File: rtl/collision_probe.sv
// Hitbox collision probe: one tile query per cycle, done strobe N+1 cycles after start (N=4, or 8 with PROBE_MIDPOINT_EN).
// No backpressure: the map answers same-cycle; start is ignored unless idle.
module collision_probe
    import collision_probe_pkg::*;
#(
    parameter int HIT_W = 31,
    parameter int HIT_H = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9:0]           px,
    input  logic [9:0]           py,
    collision_probe_if.master    q,
    output logic                 busy,
    output logic                 done,
    output logic [N_PTS-1:0]     hit_mask,
    output logic                 blocked
);

    state_t     state;
    state_t     state_nxt;
    pt_idx_t    idx;
    logic [9:0] base_x;
    logic [9:0] base_y;
    logic       accept;
    logic [9:0] pt_qx;
    logic [9:0] pt_qy;
    logic       pt_ovf;

    probe_point_gen #(
        .HIT_W (HIT_W),
        .HIT_H (HIT_H)
    ) u_point_gen (
        .base_x (base_x),
        .base_y (base_y),
        .idx    (idx),
        .qx     (pt_qx),
        .qy     (pt_qy),
        .ovf    (pt_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            base_x   <= '0;
            base_y   <= '0;
            hit_mask <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_x   <= px;
                base_y   <= py;
                idx      <= '0;
                hit_mask <= '0;
            end else if (state == S_PROBE) begin
                for (int i = 0; i < N_PTS; i++) begin
                    if (idx == pt_idx_t'(i)) begin
                        hit_mask[i] <= pt_ovf | q.qdata;
                    end
                end
                idx <= (idx == PT_LAST) ? '0 : idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_PROBE;
                end
            end
            S_PROBE: begin
                if (idx == PT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        busy     = (state == S_PROBE) || (state == S_DONE);
        done     = (state == S_DONE);
        q.qvalid = (state == S_PROBE);
        q.qx     = q.qvalid ? pt_qx : '0;
        q.qy     = q.qvalid ? pt_qy : '0;
    end

    assign blocked = |hit_mask;

endmodule
